mux_pair_seq: RTL and testbench
===============================

Name: mux_pair_seq

Overview:
- Sequencer for the 10-input, 2-output 5-bit pair multiplexer in the IQ demodulator.
- On a start pulse it walks the pair select through pairs 0..NUM_PAIRS-1, presenting one (out1, out2) pair per step to a downstream consumer.
- Pairs move to the consumer under a valid/ready handshake.
- When idle, the select is parked at an unused code so the mux drives zeros.

Parameters:
- NUM_PAIRS, 5, number of pairs per pass (legal 1..2^SEL_W-1).
- SEL_W, 3, width of the select bus.
- STEP_DIV, 1, cycles per step: 1 = back-to-back pairs; N>1 = N-1 idle gap cycles after each accepted pair (legal 1..255).

Ports:
- clk  in  1  system clock, rising edge
- nrst  in  1  asynchronous active-low reset
- start  in  1  single-cycle request to begin a pass
- abort  in  1  synchronous abort of the current pass
- pair_ready  in  1  downstream accepts the current pair
- sel  out  SEL_W  select to the pair mux
- pair_valid  out  1  mux outputs hold a valid pair
- busy  out  1  a pass is in progress
- done  out  1  one-cycle pulse, pass completed
- start_err  out  1  one-cycle pulse, start rejected

Behaviour:
- Reset is asynchronous and active-low on nrst; the block runs on the single clock clk. All outputs are registered.
- Reset values: sel = all ones (IDLE_SEL), pair_valid=0, busy=0, done=0, start_err=0, state=IDLE, gap counter=0.
- The mux is combinational, so pair data is valid in the same cycle as sel/pair_valid.
- States: IDLE, RUN, GAP, DONE. busy=1 in RUN and GAP.
- IDLE: sel=IDLE_SEL, pair_valid=0. start=1 -> RUN next cycle with sel=0, pair_valid=1.
- RUN, pair_valid=1, sel held stable while pair_ready=0.
  - pair_ready=1 and sel<NUM_PAIRS-1, STEP_DIV=1 -> stay in RUN, sel+1.
  - pair_ready=1 and sel<NUM_PAIRS-1, STEP_DIV>1 -> GAP: pair_valid=0, sel keeps its current value, counter loaded with STEP_DIV-1.
  - pair_ready=1 and sel=NUM_PAIRS-1 -> DONE: sel=IDLE_SEL, pair_valid=0.
- GAP: counter decrements each cycle. At counter=1 -> RUN with sel+1, pair_valid=1. Total gap = STEP_DIV-1 cycles.
- DONE: done=1 for exactly one cycle, then IDLE.
  - start=1 while in DONE is accepted: next state RUN, sel=0, done still 1 in the DONE cycle.
- start while in RUN or GAP: ignored; start_err=1 in the following cycle; the pass is unaffected.
- abort (any state except IDLE): next cycle IDLE, sel=IDLE_SEL, pair_valid=0, no done pulse.
  - abort has priority over pair_ready and start in the same cycle.
  - abort in IDLE has no effect.
- Handshake: transfer occurs on a cycle with pair_valid=1 and pair_ready=1. No pair is skipped or repeated. pair_valid never drops without a transfer except on abort or reset.
- Counter width: SEL_W for sel; 8 bits for the gap counter. No wrap past NUM_PAIRS-1.
- Reset mid-pass: immediate return to reset values; no done pulse.

Optional Feature:
- Macro MUX_PAIR_SEQ_LOOP_EN.
- Defined:
  - Adds input loop_mode (1 bit).
  - At acceptance of the last pair with loop_mode=1, the block bypasses DONE: done pulses in the next cycle, state RUN (or GAP if STEP_DIV>1), next presented sel=0, busy stays 1.
  - Looping continues until loop_mode=0 at a last-pair acceptance (normal DONE) or until abort.
  - start during looping -> start_err.
- Not defined: port absent; every pass is single-shot, as described above.

Test Plan:
- Reset, then STEP_DIV=1, pair_ready=1, start pulse at cycle 0 -> sel=0,1,2,3,4 on cycles 1-5 with pair_valid=1; done=1 on cycle 6; sel=7, busy=0 on cycle 7.
- Backpressure: pair_ready=0 for 3 cycles while sel=2 -> sel holds 2 and pair_valid stays 1 for those cycles; the sequence resumes 3,4 with no skip or repeat (scoreboard 5 transfers).
- STEP_DIV=3 -> each accepted pair is followed by 2 cycles of pair_valid=0; pass takes 5 + 4*2 = 13 cycles of RUN/GAP before done.
- start at sel=3 -> start_err=1 next cycle, pass completes normally. abort at sel=2 together with pair_ready=1 -> next cycle IDLE, sel=7, no done pulse.
- nrst low mid-pass at sel=1 (asynchronous, mid-cycle) -> outputs take reset values immediately. start in the DONE cycle -> sel=0 on the following cycle (back-to-back passes).
- With MUX_PAIR_SEQ_LOOP_EN and loop_mode=1 -> sel 0..4,0..4 continuous, done pulses once per wrap, busy held at 1. Clearing loop_mode before the second sel=4 acceptance -> normal DONE, then IDLE.

Source files
------------

// File: rtl/mux_pair_seq.sv
// mux_pair_seq: walks the pair-mux select through pairs 0..NUM_PAIRS-1 on a
// start pulse and hands each pair to the consumer over valid/ready.
// When nothing is in flight the select parks at all-ones so the mux outputs zero.
// Optional feature: define MUX_PAIR_SEQ_LOOP_EN to add loop_mode, which
// restarts the walk at pair 0 after the last pair instead of finishing.
module mux_pair_seq #(
  parameter int NUM_PAIRS = 5,
  parameter int SEL_W     = 3,
  parameter int STEP_DIV  = 1
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             start,
  input  logic             abort,
  input  logic             pair_ready,
`ifdef MUX_PAIR_SEQ_LOOP_EN
  input  logic             loop_mode,
`endif
  output logic [SEL_W-1:0] sel,
  output logic             pair_valid,
  output logic             busy,
  output logic             done,
  output logic             start_err
);

  localparam logic [SEL_W-1:0] IDLE_SEL = {SEL_W{1'b1}};
  localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(NUM_PAIRS - 1);
  localparam logic [7:0]       GAP_LOAD = 8'(STEP_DIV - 1);
  localparam bit               HAS_GAP  = (STEP_DIV > 1);

  typedef enum logic [1:0] {IDLE, RUN, GAP, DONE} state_e;

  state_e           state_q;
  logic [SEL_W-1:0] sel_q;
  logic             pairValid_q;
  logic             busy_q;
  logic             done_q;
  logic             startErr_q;
  logic [7:0]       gapCnt_q;

  logic [SEL_W-1:0] selStep_d;
  logic             wrap_d;

  // Next pair index (wraps to 0 after the last pair) and whether a finished pass restarts.
  always_comb begin
    selStep_d = (sel_q == LAST_SEL) ? '0 : sel_q + SEL_W'(1);
    wrap_d    = 1'b0;
`ifdef MUX_PAIR_SEQ_LOOP_EN
    wrap_d    = loop_mode;
`endif
  end

  // Sequencer FSM; every output is a register updated here, abort always wins.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q     <= IDLE;
      sel_q       <= IDLE_SEL;
      pairValid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      startErr_q  <= 1'b0;
      gapCnt_q    <= '0;
    end else begin
      done_q     <= 1'b0;
      startErr_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q     <= RUN;
            sel_q       <= '0;
            pairValid_q <= 1'b1;
            busy_q      <= 1'b1;
          end
        end
        RUN: begin
          if (abort) begin
            state_q     <= IDLE;
            sel_q       <= IDLE_SEL;
            pairValid_q <= 1'b0;
            busy_q      <= 1'b0;
            gapCnt_q    <= '0;
          end else begin
            startErr_q <= start;
            if (pair_ready) begin
              if (sel_q != LAST_SEL || wrap_d) begin
                if (sel_q == LAST_SEL) begin
                  done_q <= 1'b1;
                end
                if (HAS_GAP) begin
                  state_q     <= GAP;
                  pairValid_q <= 1'b0;
                  gapCnt_q    <= GAP_LOAD;
                end else begin
                  sel_q <= selStep_d;
                end
              end else begin
                state_q     <= DONE;
                sel_q       <= IDLE_SEL;
                pairValid_q <= 1'b0;
                busy_q      <= 1'b0;
                done_q      <= 1'b1;
              end
            end
          end
        end
        GAP: begin
          if (abort) begin
            state_q     <= IDLE;
            sel_q       <= IDLE_SEL;
            pairValid_q <= 1'b0;
            busy_q      <= 1'b0;
            gapCnt_q    <= '0;
          end else begin
            startErr_q <= start;
            if (gapCnt_q <= 8'd1) begin
              state_q     <= RUN;
              sel_q       <= selStep_d;
              pairValid_q <= 1'b1;
              gapCnt_q    <= '0;
            end else begin
              gapCnt_q <= gapCnt_q - 8'd1;
            end
          end
        end
        DONE: begin
          if (start && !abort) begin
            state_q     <= RUN;
            sel_q       <= '0;
            pairValid_q <= 1'b1;
            busy_q      <= 1'b1;
          end else begin
            state_q <= IDLE;
          end
        end
        default: begin
          state_q     <= IDLE;
          sel_q       <= IDLE_SEL;
          pairValid_q <= 1'b0;
          busy_q      <= 1'b0;
          gapCnt_q    <= '0;
        end
      endcase
    end
  end

  assign sel        = sel_q;
  assign pair_valid = pairValid_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign start_err  = startErr_q;

endmodule

// File: tb/tb_mux_pair_seq.sv
// tb_mux_pair_seq: drives two sequencers (STEP_DIV=1 and STEP_DIV=3) from the
// same inputs and compares them every cycle against a pass-level model.
module tb_mux_pair_seq;

  localparam int NP = 5;
  localparam int SW = 3;

  logic clk = 1'b0;
  logic nrst = 1'b0;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic pairReady = 1'b0;
  logic loopMode = 1'b0;

  logic [SW-1:0] selW [2];
  logic validW [2];
  logic busyW [2];
  logic doneW [2];
  logic errW [2];

  int checks = 0;
  int failures = 0;
  bit checkEn = 1'b0;
  bit logXfer = 1'b0;
  int xferQ[$];

  // Model of one pass: which pair is offered next, gap cycles still owed,
  // the last pair handed over, and the two one-cycle flags.
  typedef struct packed {
    int cp;
    int gl;
    int la;
    bit act;
    bit dn;
    bit er;
  } mstate_t;

  mstate_t ms [2];

  mux_pair_seq #(.NUM_PAIRS(NP), .SEL_W(SW), .STEP_DIV(1)) dutA (
    .clk(clk), .nrst(nrst), .start(start), .abort(abort), .pair_ready(pairReady),
`ifdef MUX_PAIR_SEQ_LOOP_EN
    .loop_mode(loopMode),
`endif
    .sel(selW[0]), .pair_valid(validW[0]), .busy(busyW[0]), .done(doneW[0]), .start_err(errW[0])
  );

  mux_pair_seq #(.NUM_PAIRS(NP), .SEL_W(SW), .STEP_DIV(3)) dutB (
    .clk(clk), .nrst(nrst), .start(start), .abort(abort), .pair_ready(pairReady),
`ifdef MUX_PAIR_SEQ_LOOP_EN
    .loop_mode(loopMode),
`endif
    .sel(selW[1]), .pair_valid(validW[1]), .busy(busyW[1]), .done(doneW[1]), .start_err(errW[1])
  );

  always #5 clk = ~clk;

  function automatic int stepOf(int i);
    return (i == 0) ? 1 : 3;
  endfunction

  function automatic mstate_t modelStep(mstate_t s, int sd, bit st, bit ab, bit rd, bit lp);
    mstate_t n;
    n = s;
    n.dn = 1'b0;
    n.er = 1'b0;
    if (s.act) begin
      if (ab) begin
        n.act = 1'b0;
      end else begin
        n.er = st;
        if (s.gl > 0) begin
          n.gl = s.gl - 1;
        end else if (rd) begin
          n.la = s.cp;
          if (s.cp == NP - 1) begin
            n.dn = 1'b1;
            if (lp) begin
              n.cp = 0;
              n.gl = sd - 1;
            end else begin
              n.act = 1'b0;
            end
          end else begin
            n.cp = s.cp + 1;
            n.gl = sd - 1;
          end
        end
      end
    end else if (st && !(s.dn && ab)) begin
      n.act = 1'b1;
      n.cp = 0;
      n.gl = 0;
    end
    return n;
  endfunction

  function automatic int expSel(mstate_t s);
    if (!s.act) return 7;
    if (s.gl > 0) return s.la;
    return s.cp;
  endfunction

  task automatic checkOutput(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  task automatic applyStimulus(bit st, bit ab, bit rd);
    start = st;
    abort = ab;
    pairReady = rd;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic waitIdle(int bound);
    int n;
    n = 0;
    while ((ms[0].act || ms[1].act || ms[0].dn || ms[1].dn) && n < bound) begin
      cyc();
      n++;
    end
    checkOutput("waitIdle.stillBusy", int'(ms[0].act || ms[1].act || ms[0].dn || ms[1].dn), 0);
  endtask

  // Advance the model on the same edge the DUTs see, with the same async reset.
  always @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int i = 0; i < 2; i++) ms[i] <= '0;
    end else begin
      for (int i = 0; i < 2; i++)
        ms[i] <= modelStep(ms[i], stepOf(i), start, abort, pairReady, loopMode);
    end
  end

  // Compare both DUTs to the model every falling edge and log transfers of dutA.
  always @(negedge clk) begin
    if (checkEn) begin
      for (int i = 0; i < 2; i++) begin
        checkOutput($sformatf("m%0d.sel", i), int'(selW[i]), expSel(ms[i]));
        checkOutput($sformatf("m%0d.valid", i), int'(validW[i]), int'(ms[i].act && ms[i].gl == 0));
        checkOutput($sformatf("m%0d.busy", i), int'(busyW[i]), int'(ms[i].act));
        checkOutput($sformatf("m%0d.done", i), int'(doneW[i]), int'(ms[i].dn));
        checkOutput($sformatf("m%0d.startErr", i), int'(errW[i]), int'(ms[i].er));
      end
    end
    if (logXfer && validW[0] && pairReady) xferQ.push_back(int'(selW[0]));
  end

  // Safety net so a stuck run still ends with a visible failure.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog");
  end

  // Directed scenarios with hand-computed values, then a randomized soak.
  initial begin
    int busyA, busyB, validB;
    busyA = 0;
    busyB = 0;
    validB = 0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset.selA", int'(selW[0]), 7);
    checkOutput("reset.selB", int'(selW[1]), 7);
    checkOutput("reset.valid", int'(validW[0]), 0);
    checkOutput("reset.busy", int'(busyW[0]), 0);
    checkOutput("reset.done", int'(doneW[0]), 0);
    checkOutput("reset.startErr", int'(errW[0]), 0);
    @(posedge clk);
    #1;
    nrst = 1'b1;
    checkEn = 1'b1;

    // Single pass, consumer always ready
    applyStimulus(1, 0, 1);
    cyc();
    start = 1'b0;
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      if (c <= 7) begin
        checkOutput($sformatf("t1.sel.c%0d", c), int'(selW[0]), (c <= 5) ? c - 1 : 7);
        checkOutput($sformatf("t1.valid.c%0d", c), int'(validW[0]), int'(c <= 5));
        checkOutput($sformatf("t1.done.c%0d", c), int'(doneW[0]), int'(c == 6));
        checkOutput($sformatf("t1.busy.c%0d", c), int'(busyW[0]), int'(c <= 5));
      end
      if (c == 14) checkOutput("t1.doneB.c14", int'(doneW[1]), 1);
      busyA += int'(busyW[0]);
      busyB += int'(busyW[1]);
      validB += int'(validW[1]);
      cyc();
    end
    checkOutput("t1.busyCyclesA", busyA, 5);
    checkOutput("t1.busyCyclesB", busyB, 13);
    checkOutput("t1.validCyclesB", validB, 5);
    waitIdle(50);

    // Backpressure while pair 2 is offered
    xferQ.delete();
    logXfer = 1'b1;
    applyStimulus(1, 0, 1);
    cyc();
    start = 1'b0;
    cyc();
    cyc();
    pairReady = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checkOutput("t2.holdSel", int'(selW[0]), 2);
      checkOutput("t2.holdValid", int'(validW[0]), 1);
      cyc();
    end
    pairReady = 1'b1;
    for (int k = 2; k <= 4; k++) begin
      @(negedge clk);
      checkOutput("t2.resumeSel", int'(selW[0]), k);
      cyc();
    end
    waitIdle(60);
    logXfer = 1'b0;
    checkOutput("t2.xferCount", xferQ.size(), 5);
    for (int k = 0; k < xferQ.size() && k < 5; k++)
      checkOutput($sformatf("t2.xfer%0d", k), xferQ[k], k);

    // start while busy is flagged but harmless
    applyStimulus(1, 0, 1);
    cyc();
    start = 1'b0;
    repeat (3) cyc();
    start = 1'b1;
    @(negedge clk);
    checkOutput("t3.selAtStart", int'(selW[0]), 3);
    cyc();
    start = 1'b0;
    @(negedge clk);
    checkOutput("t3.startErr", int'(errW[0]), 1);
    checkOutput("t3.selAfter", int'(selW[0]), 4);
    cyc();
    @(negedge clk);
    checkOutput("t3.doneNormal", int'(doneW[0]), 1);
    waitIdle(60);

    // Abort together with pair_ready at pair 2
    applyStimulus(1, 0, 1);
    cyc();
    start = 1'b0;
    cyc();
    cyc();
    abort = 1'b1;
    @(negedge clk);
    checkOutput("t4.selBeforeAbort", int'(selW[0]), 2);
    cyc();
    abort = 1'b0;
    @(negedge clk);
    checkOutput("t4.selIdle", int'(selW[0]), 7);
    checkOutput("t4.valid", int'(validW[0]), 0);
    checkOutput("t4.busy", int'(busyW[0]), 0);
    checkOutput("t4.noDone", int'(doneW[0]), 0);
    cyc();
    @(negedge clk);
    checkOutput("t4.noDoneLater", int'(doneW[0]), 0);
    waitIdle(60);

    // Asynchronous reset in the middle of a cycle while pair 1 is offered
    applyStimulus(1, 0, 1);
    cyc();
    start = 1'b0;
    cyc();
    @(negedge clk);
    checkOutput("t5.selBeforeReset", int'(selW[0]), 1);
    #2;
    nrst = 1'b0;
    #1;
    checkOutput("t5.rstSelA", int'(selW[0]), 7);
    checkOutput("t5.rstValidA", int'(validW[0]), 0);
    checkOutput("t5.rstBusyA", int'(busyW[0]), 0);
    checkOutput("t5.rstBusyB", int'(busyW[1]), 0);
    checkOutput("t5.rstDoneA", int'(doneW[0]), 0);
    cyc();
    nrst = 1'b1;
    cyc();

    // start in the done cycle gives back-to-back passes
    applyStimulus(1, 0, 1);
    cyc();
    start = 1'b0;
    repeat (5) cyc();
    start = 1'b1;
    @(negedge clk);
    checkOutput("t6.doneCycle", int'(doneW[0]), 1);
    cyc();
    start = 1'b0;
    @(negedge clk);
    checkOutput("t6.restartSel", int'(selW[0]), 0);
    checkOutput("t6.restartValid", int'(validW[0]), 1);
    checkOutput("t6.restartBusy", int'(busyW[0]), 1);
    waitIdle(100);

`ifdef MUX_PAIR_SEQ_LOOP_EN
    // Looping passes, then a normal finish once loop_mode drops
    loopMode = 1'b1;
    applyStimulus(1, 0, 1);
    cyc();
    start = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      if (c == 10) loopMode = 1'b0;
      @(negedge clk);
      if (c <= 10) begin
        checkOutput($sformatf("t7.sel.c%0d", c), int'(selW[0]), (c - 1) % 5);
        checkOutput($sformatf("t7.busy.c%0d", c), int'(busyW[0]), 1);
      end else begin
        checkOutput($sformatf("t7.selEnd.c%0d", c), int'(selW[0]), 7);
        checkOutput($sformatf("t7.busyEnd.c%0d", c), int'(busyW[0]), 0);
      end
      checkOutput($sformatf("t7.done.c%0d", c), int'(doneW[0]), int'(c == 6 || c == 11));
      cyc();
    end
    waitIdle(100);
`endif

    // Randomized soak; the compare process does all the checking here
    for (int n = 0; n < 3000; n++) begin
      start = ($urandom_range(0, 5) == 0);
      abort = ($urandom_range(0, 39) == 0);
      pairReady = ($urandom_range(0, 9) < 6);
`ifdef MUX_PAIR_SEQ_LOOP_EN
      loopMode = ($urandom_range(0, 3) != 0);
`endif
      cyc();
    end
    applyStimulus(0, 0, 1);
    loopMode = 1'b0;
    waitIdle(100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
